// File: rtl/gsensor_spi.sv
// Autonomous SPI master (mode 3, MSB first) for the ADXL345 accelerometer.
// Configures the sensor after reset, then burst-reads X/Y/Z every SAMPLE_DIV clocks.
module gsensor_spi #(
    parameter int CLK_DIV    = 25,
    parameter int SAMPLE_DIV = 500000
) (
    input  logic        clk1_50,
    input  logic        rst_,
    input  logic        gsensor_sdo,
    output logic        gsensor_cs_,
    output logic        gsensor_sclk,
    output logic        gsensor_sdi,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        accel_valid,
    output logic        cfg_done
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int SW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CAP_CNT   = CW'(1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [6:0]    WR_HALF_LAST = 7'd33;
    localparam logic [6:0]    RD_HALF_LAST = 7'd113;

    typedef enum logic [2:0] {
        S_WAIT, S_WR_FMT, S_GAP1, S_WR_PWR, S_IDLE, S_RD
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_half;
    logic [55:0]   r_tx;
    logic [47:0]   r_rx;
    logic [1:0]    r_sync;
    logic [SW-1:0] r_samp;
    logic          r_cs_;
    logic          r_sclk;
    logic          r_sdi;
    logic [15:0]   r_x;
    logic [15:0]   r_y;
    logic [15:0]   r_z;
    logic          r_valid;
    logic          r_cfg_done;

    logic          w_start;
    logic          w_end;
    logic          w_xfer;
    logic          w_div_last;
    logic          w_gap_last;
    logic          w_samp_exp;
    logic [6:0]    w_half_last;
    logic [55:0]   w_frame;

    always_ff @(posedge clk1_50 or negedge rst_) begin
        if (!rst_) r_state <= S_WAIT;
        else       r_state <= w_state_nxt;
    end

    // Frame halves: 0 = setup, odd = SCLK low, even = SCLK high, last = hold.
    always_comb begin
        w_half_last = (r_state == S_RD) ? RD_HALF_LAST : WR_HALF_LAST;
        w_xfer      = (r_state == S_WR_FMT) || (r_state == S_WR_PWR) || (r_state == S_RD);
        w_div_last  = (r_cnt == DIV_LAST);
        w_gap_last  = (r_cnt == GAP_LAST);
        w_samp_exp  = r_cfg_done && (r_samp == SAMP_LAST);
        w_end       = w_xfer && w_div_last && (r_half == w_half_last);
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_frame     = '0;
        case (r_state)
            S_WAIT: if (w_gap_last) begin
                w_state_nxt = S_WR_FMT;
                w_start     = 1'b1;
                w_frame     = {8'h31, 8'h08, 40'h0};
            end
            S_WR_FMT: if (w_end) w_state_nxt = S_GAP1;
            S_GAP1: if (w_gap_last) begin
                w_state_nxt = S_WR_PWR;
                w_start     = 1'b1;
                w_frame     = {8'h2D, 8'h08, 40'h0};
            end
            S_WR_PWR: if (w_end) w_state_nxt = S_IDLE;
            S_IDLE: if (w_samp_exp) begin
                w_state_nxt = S_RD;
                w_start     = 1'b1;
                w_frame     = {8'hF2, 48'h0};
            end
            S_RD: if (w_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk1_50 or negedge rst_) begin
        if (!rst_) begin
            r_cnt      <= '0;
            r_half     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_sync     <= '0;
            r_samp     <= '0;
            r_cs_      <= 1'b1;
            r_sclk     <= 1'b1;
            r_sdi      <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_valid    <= 1'b0;
            r_cfg_done <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], gsensor_sdo};
            r_valid <= 1'b0;

            if (r_cfg_done) r_samp <= (r_samp == SAMP_LAST) ? '0 : r_samp + 1'b1;

            if (w_start || w_end)                          r_cnt <= '0;
            else if (w_xfer)                               r_cnt <= w_div_last ? '0 : r_cnt + 1'b1;
            else if (r_state == S_WAIT || r_state == S_GAP1) r_cnt <= r_cnt + 1'b1;

            if (w_start)                   r_half <= '0;
            else if (w_xfer && w_div_last) r_half <= r_half + 1'b1;

            if (w_start) begin
                r_cs_  <= 1'b0;
                r_sclk <= 1'b1;
                r_sdi  <= w_frame[55];
                r_tx   <= w_frame;
            end else if (w_end) begin
                r_cs_  <= 1'b1;
                r_sclk <= 1'b1;
                r_sdi  <= 1'b0;
            end else if (w_xfer && w_div_last) begin
                if (!r_half[0] && ((r_half + 7'd1) != w_half_last)) begin
                    r_sclk <= 1'b0;
                    r_sdi  <= r_tx[55];
                    r_tx   <= {r_tx[54:0], 1'b0};
                end else if (r_half[0]) begin
                    r_sclk <= 1'b1;
                end
            end

            // r_sync[1] two cycles after a rising edge holds sdo as seen at that edge.
            if (r_state == S_RD && !r_half[0] && r_half != '0 && r_cnt == CAP_CNT)
                r_rx <= {r_rx[46:0], r_sync[1]};

            if (w_end && r_state == S_RD) begin
                r_x     <= {r_rx[39:32], r_rx[47:40]};
                r_y     <= {r_rx[23:16], r_rx[31:24]};
                r_z     <= {r_rx[7:0],   r_rx[15:8]};
                r_valid <= 1'b1;
            end
            if (w_end && r_state == S_WR_PWR) begin
                r_cfg_done <= 1'b1;
                r_samp     <= '0;
            end
        end
    end

    assign gsensor_cs_  = r_cs_;
    assign gsensor_sclk = r_sclk;
    assign gsensor_sdi  = r_sdi;
    assign accel_x      = r_x;
    assign accel_y      = r_y;
    assign accel_z      = r_z;
    assign accel_valid  = r_valid;
    assign cfg_done     = r_cfg_done;
endmodule

// File: tb/tb_gsensor_spi.sv
// Bench for gsensor_spi: behavioural ADXL345 mode-3 slave with random sample data,
// sample scoreboard, and transaction-shape / timing checks.
`timescale 1ns/1ps
module tb_gsensor_spi;
    localparam int CLK_DIV    = 2;
    localparam int SAMPLE_DIV = 400;
    localparam int WR_LOW     = (2 * 16 + 2) * CLK_DIV;
    localparam int RD_LOW     = (2 * 56 + 2) * CLK_DIV;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } samp_t;

    typedef struct {
        logic [63:0] rx;
        int          nbits;
        int          low;
        longint      fall;
        longint      rise;
    } txn_t;

    logic        clk;
    logic        rst_;
    logic        gsensor_sdo;
    logic        gsensor_cs_;
    logic        gsensor_sclk;
    logic        gsensor_sdi;
    logic [15:0] accel_x;
    logic [15:0] accel_y;
    logic [15:0] accel_z;
    logic        accel_valid;
    logic        cfg_done;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint cfg_rise = -1;
    int     n_valid = 0;
    int     n_exp_valid = 0;
    int     stable_err = 0;

    samp_t       exp_q[$];
    txn_t        txn_q[$];
    logic [47:0] frame_q[$];

    gsensor_spi #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(SAMPLE_DIV)) dut (
        .clk1_50      (clk),
        .rst_         (rst_),
        .gsensor_sdo  (gsensor_sdo),
        .gsensor_cs_  (gsensor_cs_),
        .gsensor_sclk (gsensor_sclk),
        .gsensor_sdi  (gsensor_sdi),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .accel_valid  (accel_valid),
        .cfg_done     (cfg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // ADXL345 slave: captures sdi on SCLK rise, presents read data while SCLK is low
    // and toggles sdo at every other moment so only the rising-edge value is valid.
    logic        sl_cs_prev = 1'b1;
    logic        sl_sclk_prev = 1'b1;
    logic [63:0] sl_rx = '0;
    int          sl_nbits = 0;
    int          sl_low = 0;
    int          sl_falls = 0;
    int          sl_cur = 0;
    logic        sl_read = 1'b0;
    longint      sl_fall = 0;
    logic [47:0] sl_f;
    logic [7:0]  sl_b [6];
    samp_t       sl_s;
    txn_t        sl_t;

    initial gsensor_sdo = 1'b0;

    always @(negedge clk) begin
        if (!gsensor_cs_) begin
            if (sl_cs_prev) begin
                sl_rx = '0; sl_nbits = 0; sl_low = 0; sl_falls = 0; sl_cur = 0;
                sl_read = 1'b0; sl_fall = cyc;
            end
            sl_low++;
            if (!sl_sclk_prev && gsensor_sclk) begin
                sl_rx = {sl_rx[62:0], gsensor_sdi};
                sl_nbits++;
                if (sl_nbits == 8 && sl_rx[7]) begin
                    sl_read = 1'b1;
                    if (frame_q.size() != 0) sl_f = frame_q.pop_front();
                    else                     sl_f = {16'($urandom), 32'($urandom)};
                    for (int n = 0; n < 6; n++) sl_b[n] = sl_f[8*n +: 8];
                    sl_s.x = {sl_b[1], sl_b[0]};
                    sl_s.y = {sl_b[3], sl_b[2]};
                    sl_s.z = {sl_b[5], sl_b[4]};
                    exp_q.push_back(sl_s);
                end
            end
            if (sl_sclk_prev && !gsensor_sclk) begin
                sl_cur = sl_falls;
                sl_falls++;
            end
        end else if (!sl_cs_prev) begin
            sl_t.rx = sl_rx; sl_t.nbits = sl_nbits; sl_t.low = sl_low;
            sl_t.fall = sl_fall; sl_t.rise = cyc;
            txn_q.push_back(sl_t);
        end
        if (!gsensor_cs_ && !gsensor_sclk && sl_read && sl_cur >= 8)
            gsensor_sdo = sl_b[(sl_cur - 8) / 8][7 - ((sl_cur - 8) % 8)];
        else
            gsensor_sdo = ~gsensor_sdo;
        sl_cs_prev   = gsensor_cs_;
        sl_sclk_prev = gsensor_sclk;
    end

    // Sample scoreboard / output monitor.
    samp_t m_model = '0;
    samp_t m_e;
    logic  m_cs_prev = 1'b1;
    logic  m_valid_prev = 1'b0;
    logic  m_cfg_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_) begin
            m_model = '0;
        end else if (accel_valid) begin
            n_valid++;
            chk("sample_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                m_e = exp_q.pop_front();
                chk("accel_x", accel_x, m_e.x);
                chk("accel_y", accel_y, m_e.y);
                chk("accel_z", accel_z, m_e.z);
                m_model = m_e;
            end
            chk("valid_at_cs_rise", {m_cs_prev, gsensor_cs_}, 2'b01);
            chk("valid_one_cycle", m_valid_prev, 0);
        end else if ({accel_x, accel_y, accel_z} != m_model) begin
            stable_err++;
        end
        if (cfg_done && !m_cfg_prev) cfg_rise = cyc;
        m_cs_prev    = gsensor_cs_;
        m_valid_prev = accel_valid;
        m_cfg_prev   = cfg_done;
    end

    task automatic get_txn(output txn_t t);
        int n = 0;
        while (txn_q.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (txn_q.size() == 0) begin
            chk("txn_timeout", 0, 1);
            finish_tb();
        end
        t = txn_q.pop_front();
    endtask

    task automatic check_config(input longint rel);
        txn_t   t;
        longint prev_rise;
        get_txn(t);
        chk("wr1_start_delay", t.fall - rel, 2 * CLK_DIV);
        chk("wr1_bits", t.nbits, 16);
        chk("wr1_data", t.rx[15:0], 16'h3108);
        chk("wr1_cs_low", t.low, WR_LOW);
        prev_rise = t.rise;
        get_txn(t);
        chk("gap1_cycles", t.fall - prev_rise, 2 * CLK_DIV);
        chk("wr2_bits", t.nbits, 16);
        chk("wr2_data", t.rx[15:0], 16'h2D08);
        chk("wr2_cs_low", t.low, WR_LOW);
        @(negedge clk);
        chk("cfg_done_rise", cfg_rise, t.rise);
    endtask

    task automatic check_read(input longint prev_fall, output longint fall);
        txn_t t;
        get_txn(t);
        chk("rd_bits", t.nbits, 56);
        chk("rd_cmd", t.rx[55:48], 8'hF2);
        chk("rd_sdi_zero", t.rx[47:0], 48'h0);
        chk("rd_cs_low", t.low, RD_LOW);
        chk("rd_period", t.fall - prev_fall, SAMPLE_DIV);
        chk("cfg_done_held", cfg_done, 1);
        n_exp_valid++;
        fall = t.fall;
    endtask

    initial begin
        longint rel;
        longint last_fall;
        txn_t   t;
        int     n;

        rst_ = 1'b0;
        frame_q.push_back(48'h8000_FFFE_1234);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_pins", {gsensor_cs_, gsensor_sclk, gsensor_sdi, accel_valid, cfg_done}, 5'b11000);
            chk("rst_accel", {accel_x, accel_y, accel_z}, 48'h0);
        end

        rst_ = 1'b1;
        rel  = cyc;
        check_config(rel);
        last_fall = cfg_rise;
        for (int i = 0; i < 4; i++) check_read(last_fall, last_fall);

        n = 0;
        while (!(!gsensor_cs_ && sl_read && sl_nbits == 30) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_read_bit30", sl_nbits, 30);
        #2 rst_ = 1'b0;
        #1;
        chk("async_rst_cs_sclk", {gsensor_cs_, gsensor_sclk, gsensor_sdi}, 3'b110);
        chk("async_rst_outputs", {accel_valid, cfg_done, accel_x, accel_y, accel_z}, 50'h0);
        exp_q.delete();
        cfg_rise = -1;
        get_txn(t);
        chk("partial_frame_bits", t.nbits, 30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst2_pins", {gsensor_cs_, gsensor_sclk, accel_valid, cfg_done}, 4'b1100);
        end

        rst_ = 1'b1;
        rel  = cyc;
        check_config(rel);
        last_fall = cfg_rise;
        check_read(last_fall, last_fall);

        repeat (3) @(negedge clk);
        chk("valid_count", n_valid, n_exp_valid);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("outputs_stable", stable_err, 0);
        finish_tb();
    end

    initial begin
        #1000000;
        chk("watchdog", 0, 1);
        finish_tb();
    end
endmodule
